// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - snapshots N_ELEM result words and streams them byte-serially over a 4-phase valid/ack handshake
// Optional trailing XOR checksum byte: define RESULT_SERIALIZER_CHECKSUM_EN.
`timescale 1ns/1ps
module result_serializer #(
  parameter int N_ELEM = 9,
  parameter int ELEM_W = 18
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N_ELEM*ELEM_W-1:0]   results,
  input  logic                       host_ack,
  output logic [7:0]                 data_out,
  output logic                       data_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int BPE         = (ELEM_W + 7) / 8;
  localparam int BYTES_TOTAL = N_ELEM * BPE;
  localparam int IDX_W       = $clog2(BYTES_TOTAL + 1);
  localparam int ARR_N       = 2 ** IDX_W;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES_TOTAL);
`else
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES_TOTAL - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_LOW,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [N_ELEM*ELEM_W-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]           idx_q, idx_d, next_idx;
  logic [7:0]                 dout_q, dout_d;
  logic                       valid_q, valid_d;
  logic                       sync1_q, ack_s_q;
  logic [7:0]                 byte_arr [ARR_N];
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
  logic [7:0]                 csum_q, csum_d;
`endif

  // Byte view of the snapshot, sized to the full index range so byte_idx never indexes out of bounds.
  always_comb begin
    logic [BPE*8-1:0] word_pad;
    for (int i = 0; i < ARR_N; i++) byte_arr[i] = '0;
    for (int k = 0; k < N_ELEM; k++) begin
      word_pad = '0;
      word_pad[ELEM_W-1:0] = snap_q[k*ELEM_W +: ELEM_W];
      for (int j = 0; j < BPE; j++) byte_arr[k*BPE + j] = word_pad[j*8 +: 8];
    end
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    byte_arr[BYTES_TOTAL] = csum_q;
`endif
  end

  assign next_idx = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    valid_d = valid_q;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        dout_d  = '0;
        valid_d = 1'b0;
        if (start) begin
          snap_d  = results;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
        csum_d = '0;
`endif
        // An ack still high from a previous transfer must clear before byte 0 is offered.
        if (!ack_s_q) begin
          dout_d  = byte_arr[idx_q];
          valid_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (ack_s_q) begin
          valid_d = 1'b0;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
          csum_d  = csum_q ^ dout_q;
`endif
          state_d = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!ack_s_q) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = next_idx;
            dout_d  = byte_arr[next_idx];
            valid_d = 1'b1;
            state_d = S_SEND;
          end
        end
      end
      S_DONE: begin
        if (!start) begin
          dout_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        dout_d  = '0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      sync1_q <= 1'b0;
      ack_s_q <= 1'b0;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      sync1_q <= host_ack;
      ack_s_q <= sync1_q;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_SEND) || (state_q == S_WAIT_LOW);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - directed bench for result_serializer with a byte-queue reference model
`timescale 1ns/1ps
module tb_result_serializer;

  localparam int N_ELEM = 9;
  localparam int ELEM_W = 18;
  localparam int BPE    = 3;
  localparam int BT     = N_ELEM * BPE;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
  localparam int NB = BT + 1;
`else
  localparam int NB = BT;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic [N_ELEM*ELEM_W-1:0] results;
  logic                     host_ack;
  logic [7:0]               data_out;
  logic                     data_valid;
  logic                     busy;
  logic                     done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         ack_count = 0;
  int         base = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_out = 8'h00;

  result_serializer #(.N_ELEM(N_ELEM), .ELEM_W(ELEM_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .results    (results),
    .host_ack   (host_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Expected stream: words in order, LSB first, zero-padded to 24 bits, optional XOR byte last.
  function automatic void build_model(input logic [N_ELEM*ELEM_W-1:0] r);
    logic [7:0] csum;
    exp_q.delete();
    csum = 8'h00;
    for (int k = 0; k < N_ELEM; k++) begin
      logic [23:0] w;
      w = 24'(r[k*ELEM_W +: ELEM_W]);
      for (int j = 0; j < BPE; j++) begin
        exp_q.push_back(w[j*8 +: 8]);
        csum = csum ^ w[j*8 +: 8];
      end
    end
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    exp_q.push_back(csum);
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (data_valid) begin
        check("busy_while_valid", 32'(busy), 32'd1);
        if (ack_count - base < exp_q.size())
          check("byte_value", 32'(data_out), 32'(exp_q[ack_count - base]));
        else
          check("extra_byte", ack_count - base, exp_q.size());
        if (prev_valid) check("byte_stable", 32'(data_out), 32'(prev_out));
      end
      if (prev_valid && !data_valid) ack_count <= ack_count + 1;
      if (!busy && !done) begin
        check("idle_data_out", 32'(data_out), 32'd0);
        check("idle_valid", 32'(data_valid), 32'd0);
      end
      prev_valid <= data_valid;
      prev_out   <= data_out;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int t;
    t = 0;
    while (!data_valid && t < 100) begin cyc(); t++; end
    check("valid_seen", 32'(data_valid), 32'd1);
    b = data_out;
    cyc(2);
    host_ack = 1'b1;
    t = 0;
    while (data_valid && t < 20) begin cyc(); t++; end
    check("ack_clears_valid", 32'(data_valid), 32'd0);
    host_ack = 1'b0;
  endtask

  task automatic recv_n(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      recv_byte(b);
      rx_q.push_back(b);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 20) begin cyc(); t++; end
    check("done_reached", 32'(done), 32'd1);
    check("stream_len", ack_count - base, NB);
  endtask

  task automatic start_stream(input logic [N_ELEM*ELEM_W-1:0] r);
    cyc(2);
    results = r;
    build_model(r);
    base = ack_count;
    rx_q.delete();
    start = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N_ELEM*ELEM_W-1:0] r;
    rst_n = 1'b0; start = 1'b0; host_ack = 1'b0; results = '0;
    cyc(3);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Test 1 (start held high throughout, which also covers the sticky-DONE case)
    r = '0; r[17:0] = 18'h3FFFF; r[35:18] = 18'h12345;
    start_stream(r);
    cyc(1);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_valid_early", 32'(data_valid), 32'd0);
    cyc(1);
    check("lat_valid", 32'(data_valid), 32'd1);
    recv_n(NB);
    check("t1_b0", 32'(rx_q[0]), 32'hFF);
    check("t1_b1", 32'(rx_q[1]), 32'hFF);
    check("t1_b2", 32'(rx_q[2]), 32'h03);
    check("t1_b3", 32'(rx_q[3]), 32'h45);
    check("t1_b4", 32'(rx_q[4]), 32'h23);
    check("t1_b5", 32'(rx_q[5]), 32'h01);
    check("t1_b6", 32'(rx_q[6]), 32'h00);
    wait_done();
    check("done_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("done_sticky", 32'(done), 32'd1);
      check("done_no_valid", 32'(data_valid), 32'd0);
    end
    check("done_no_bytes", ack_count - base, NB);
    start = 1'b0;
    cyc(1);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Test 2: stale ack guard
    host_ack = 1'b1;
    for (int k = 0; k < N_ELEM; k++) r[k*ELEM_W +: ELEM_W] = 18'(k * 32'h1111 + 5);
    start_stream(r);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("guard_busy", 32'(busy), 32'd1);
      check("guard_valid", 32'(data_valid), 32'd0);
    end
    start = 1'b0;
    host_ack = 1'b0;
    cyc(2);
    check("guard_release_early", 32'(data_valid), 32'd0);
    cyc(1);
    check("guard_release", 32'(data_valid), 32'd1);
    recv_n(NB);
    wait_done();

    // Test 3: async reset mid-stream, then full restart
    for (int k = 0; k < N_ELEM; k++) r[k*ELEM_W +: ELEM_W] = 18'(32'h2A000 + k * 7);
    start_stream(r);
    cyc(1);
    start = 1'b0;
    recv_n(5);
    cyc(3);
    check("pre_reset_valid", 32'(data_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_data_out", 32'(data_out), 32'd0);
    check("abort_valid", 32'(data_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    start_stream(r);
    cyc(1);
    start = 1'b0;
    recv_n(NB);
    check("restart_b0", 32'(rx_q[0]), 32'h00);
    check("restart_b2", 32'(rx_q[2]), 32'h02);
    check("restart_b3", 32'(rx_q[3]), 32'h07);
    wait_done();

    // Test 4: results change after LOAD
    for (int k = 0; k < N_ELEM; k++) r[k*ELEM_W +: ELEM_W] = 18'((k * 32'h3C3C) ^ 32'h15);
    start_stream(r);
    cyc(1);
    results = '1;
    start = 1'b0;
    recv_n(NB);
    check("snap_b0", 32'(rx_q[0]), 32'h15);
    check("snap_b3", 32'(rx_q[3]), 32'h29);
    wait_done();

    // Test 5: checksum pattern (last byte 0x83 with checksum, 0x02 without)
    r = '0; r[17:0] = 18'h00001; r[8*ELEM_W +: ELEM_W] = 18'h20080;
    start_stream(r);
    cyc(1);
    start = 1'b0;
    recv_n(NB);
    check("t5_b0", 32'(rx_q[0]), 32'h01);
    check("t5_b24", 32'(rx_q[24]), 32'h80);
    check("t5_b26", 32'(rx_q[26]), 32'h02);
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    check("t5_csum", 32'(rx_q[27]), 32'h83);
`endif
    wait_done();
    cyc(2);
    check("final_idle", 32'(busy | done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
